// File: rtl/player_ship.sv
// Player ship sprite: debounced left/right/fire buttons, per-frame motion with
// clamp or wrap screen edges, fire cooldown FSM and sprite pixel generation.
module player_ship #(
  parameter int          HRES      = 1280,
  parameter int          VRES      = 720,
  parameter int          SHIP_W    = 64,
  parameter int          SHIP_H    = 32,
  parameter int          MAX_VEL   = 16,
  parameter int          ACCEL     = 2,
  parameter int          DEB       = 3,
  parameter int          EDGE_MODE = 0,
  parameter int          FIRE_CD   = 8,
  parameter logic [23:0] COLOR     = 24'hEFE62E
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               left,
  input  logic               right,
  input  logic               fire,
  output logic [2:0][7:0]    pixel,
  output logic               active,
  output logic signed [11:0] xpos,
  output logic               fire_pulse,
  output logic signed [11:0] fire_x
);

  localparam int CDW = (FIRE_CD < 1) ? 1 : $clog2(FIRE_CD + 1);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_COOL  = 1'b1;

  logic [DEB-1:0]     deb_l_q, deb_l_d, deb_r_q, deb_r_d, deb_f_q, deb_f_d;
  logic [DEB:0]       sh_l, sh_r, sh_f;
  logic               pressed_l, pressed_r, pressed_f;
  logic               lat_l_q, lat_l_d, lat_r_q, lat_r_d, lat_f_q, lat_f_d;
  logic signed [11:0] xpos_q, xpos_d, vel_q, vel_d, fire_x_q, fire_x_d;
  logic               fire_pulse_q, fire_pulse_d;
  logic [0:0]         state_q, state_d;
  logic [CDW-1:0]     cd_q, cd_d;
  int                 v_cur, v_new, nx, x_new, fx, dh, dm;
  logic               go_l, go_r, row_hit, col_hit;

  // Debounce shift registers and per-frame button latches.
  always_comb begin
    sh_l      = {deb_l_q, left};
    sh_r      = {deb_r_q, right};
    sh_f      = {deb_f_q, fire};
    deb_l_d   = sh_l[DEB-1:0];
    deb_r_d   = sh_r[DEB-1:0];
    deb_f_d   = sh_f[DEB-1:0];
    pressed_l = &deb_l_q;
    pressed_r = &deb_r_q;
    pressed_f = &deb_f_q;
    lat_l_d   = fsync ? 1'b0 : (lat_l_q | pressed_l);
    lat_r_d   = fsync ? 1'b0 : (lat_r_q | pressed_r);
    lat_f_d   = fsync ? 1'b0 : (lat_f_q | pressed_f);
  end

  // Frame-rate motion: velocity update, position advance by the old velocity, edges.
  always_comb begin
    go_l  = lat_l_q & ~lat_r_q;
    go_r  = lat_r_q & ~lat_l_q;
    v_cur = int'(vel_q);
    if (go_r) begin
      v_new = (v_cur + ACCEL > MAX_VEL) ? MAX_VEL : v_cur + ACCEL;
    end else if (go_l) begin
      v_new = (v_cur - ACCEL < -MAX_VEL) ? -MAX_VEL : v_cur - ACCEL;
    end else if (v_cur > 0) begin
      v_new = (v_cur > ACCEL) ? v_cur - ACCEL : 0;
    end else begin
      v_new = (v_cur < -ACCEL) ? v_cur + ACCEL : 0;
    end
    nx    = int'(xpos_q) + v_cur;
    x_new = nx;
    if (EDGE_MODE == 0) begin
      if (nx < 0) begin
        x_new = 0;
        v_new = 0;
      end else if (nx > HRES - SHIP_W) begin
        x_new = HRES - SHIP_W;
        v_new = 0;
      end
    end else begin
      if (nx < 0)         x_new = nx + HRES;
      else if (nx >= HRES) x_new = nx - HRES;
    end
    fx = x_new + SHIP_W / 2;
    if (EDGE_MODE != 0 && fx >= HRES) fx = fx - HRES;

    xpos_d = xpos_q;
    vel_d  = vel_q;
    if (fsync) begin
      xpos_d = 12'(x_new);
      vel_d  = 12'(v_new);
    end
  end

  // Fire FSM: a latched fire in READY shoots once, then COOL counts frames down.
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    fire_pulse_d = 1'b0;
    fire_x_d     = fire_x_q;
    if (fsync) begin
      if (state_q == ST_READY) begin
        if (lat_f_q) begin
          fire_pulse_d = 1'b1;
          fire_x_d     = 12'(fx);
          cd_d         = CDW'(FIRE_CD);
          state_d      = ST_COOL;
        end
      end else begin
        cd_d = cd_q - 1'b1;
        if (cd_d == '0) state_d = ST_READY;
      end
    end
  end

  // State registers; reset clears everything immediately, mid-frame or not.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_l_q      <= '0;
      deb_r_q      <= '0;
      deb_f_q      <= '0;
      lat_l_q      <= 1'b0;
      lat_r_q      <= 1'b0;
      lat_f_q      <= 1'b0;
      xpos_q       <= 12'((HRES - SHIP_W) / 2);
      vel_q        <= '0;
      state_q      <= ST_READY;
      cd_q         <= '0;
      fire_pulse_q <= 1'b0;
      fire_x_q     <= '0;
    end else begin
      deb_l_q      <= deb_l_d;
      deb_r_q      <= deb_r_d;
      deb_f_q      <= deb_f_d;
      lat_l_q      <= lat_l_d;
      lat_r_q      <= lat_r_d;
      lat_f_q      <= lat_f_d;
      xpos_q       <= xpos_d;
      vel_q        <= vel_d;
      state_q      <= state_d;
      cd_q         <= cd_d;
      fire_pulse_q <= fire_pulse_d;
      fire_x_q     <= fire_x_d;
    end
  end

  // Sprite hit test on the bottom rows; wrap mode measures distance modulo HRES.
  always_comb begin
    dh      = int'(hpos) - int'(xpos_q);
    dm      = (dh < 0) ? dh + HRES : dh;
    row_hit = (int'(vpos) >= VRES - SHIP_H) && (int'(vpos) <= VRES - 1);
    if (EDGE_MODE != 0) col_hit = dm < SHIP_W;
    else                col_hit = (dh >= 0) && (dh < SHIP_W);
    active  = row_hit && (int'(hpos) >= 0) && (int'(hpos) < HRES) && col_hit;
    pixel   = active ? COLOR : '0;
  end

  assign xpos       = xpos_q;
  assign fire_pulse = fire_pulse_q;
  assign fire_x     = fire_x_q;

endmodule

// File: tb/tb_player_ship.sv
// Directed bench for player_ship: one clamp-mode and one wrap-mode instance.
module tb_player_ship;

  localparam int FrameLen = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fsync_c = 1'b0, fsync_w = 1'b0;
  logic               left = 1'b0, right = 1'b0, fire = 1'b0;
  logic signed [11:0] hpos = '0, vpos = '0;

  logic [2:0][7:0]    pixel_c, pixel_w;
  logic               active_c, active_w, pulse_c, pulse_w;
  logic signed [11:0] xpos_c, xpos_w, fx_c, fx_w;

  int   n_total = 0;
  int   n_bad = 0;
  logic got_pulse;
  int   got_fx;

  always #5 clk = ~clk;

  player_ship u_clamp (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync_c), .hpos(hpos), .vpos(vpos),
    .left(left), .right(right), .fire(fire), .pixel(pixel_c), .active(active_c),
    .xpos(xpos_c), .fire_pulse(pulse_c), .fire_x(fx_c)
  );

  // A 44-pixel sprite at x=1276 covers 1276..1279 and 0..39.
  player_ship #(.EDGE_MODE(1), .SHIP_W(44)) u_wrap (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync_w), .hpos(hpos), .vpos(vpos),
    .left(left), .right(right), .fire(fire), .pixel(pixel_w), .active(active_w),
    .xpos(xpos_w), .fire_pulse(pulse_w), .fire_x(fx_w)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    left = 1'b0; right = 1'b0; fire = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One fsync cycle for the selected instance; samples the shot outputs after it.
  task automatic sync_frame(input bit sel);
    @(negedge clk);
    if (sel) fsync_w = 1'b1;
    else     fsync_c = 1'b1;
    @(negedge clk);
    fsync_c = 1'b0;
    fsync_w = 1'b0;
    got_pulse = sel ? pulse_w : pulse_c;
    got_fx    = sel ? int'(fx_w) : int'(fx_c);
  endtask

  // Buttons are dropped one cycle before fsync so no press leaks into the next frame.
  task automatic frame(input bit sel, input logic l, input logic r, input logic f);
    left = l; right = r; fire = f;
    repeat (FrameLen) @(negedge clk);
    left = 1'b0; right = 1'b0; fire = 1'b0;
    sync_frame(sel);
  endtask

  task automatic frames(input bit sel, input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) frame(sel, l, r, 1'b0);
  endtask

  int exp_x[3] = '{608, 610, 614};
  int exp_v[3] = '{2, 4, 6};
  int hp_tab[5] = '{1279, 0, 39, 40, 1275};
  int hp_exp[5] = '{1, 1, 1, 0, 0};
  int hc_tab[4] = '{607, 608, 671, 672};
  int hc_exp[4] = '{0, 1, 1, 0};
  int lr_v[4] = '{4, 2, 0, 0};

  initial begin
    // Reset state
    do_reset();
    check("rst_xpos_c", int'(xpos_c), 608);
    check("rst_xpos_w", int'(xpos_w), 618);
    check("rst_vel", int'(u_clamp.vel_q), 0);
    check("rst_pulse", int'(pulse_c), 0);
    check("rst_fire_x", int'(fx_c), 0);

    // Clamp-mode hit test around x=608..671 on a sprite row
    vpos = 12'sd700;
    for (int i = 0; i < 4; i++) begin
      hpos = 12'(hc_tab[i]);
      #1;
      check($sformatf("act_c_%0d", hc_tab[i]), int'(active_c), hc_exp[i]);
    end
    hpos = 12'sd640;
    #1;
    check("pix_on", int'(pixel_c), 32'h00EFE62E);
    vpos = 12'sd687;
    #1;
    check("act_row_above", int'(active_c), 0);
    check("pix_off", int'(pixel_c), 0);
    vpos = 12'sd719;
    #1;
    check("act_row_last", int'(active_c), 1);
    vpos = 12'sd720;
    #1;
    check("act_row_below", int'(active_c), 0);

    // Right held: acceleration ramp, then toward the right clamp
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("ramp_x%0d", i), int'(xpos_c), exp_x[i]);
      check($sformatf("ramp_v%0d", i), int'(u_clamp.vel_q), exp_v[i]);
    end
    frames(1'b0, 1'b0, 1'b1, 5);
    check("ramp_x_top", int'(xpos_c), 664);
    check("ramp_v_top", int'(u_clamp.vel_q), 16);
    // Each idle+right pair advances 16+14=30 and keeps vel at 16
    for (int i = 0; i < 7; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 1'b1, 1'b0);
    end
    frames(1'b0, 1'b0, 1'b1, 21);
    check("pre_clamp_x", int'(xpos_c), 1210);
    check("pre_clamp_v", int'(u_clamp.vel_q), 16);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("clamp_x", int'(xpos_c), 1216);
    check("clamp_v", int'(u_clamp.vel_q), 0);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_clamp_x", int'(xpos_c), 1216);
    check("post_clamp_v", int'(u_clamp.vel_q), 2);

    // Wrap mode: reach 1260 at vel 16, cross the right edge
    do_reset();
    frames(1'b1, 1'b0, 1'b1, 8);
    check("w_ramp_x", int'(xpos_w), 674);
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 1'b0, 1'b0, 1'b0);
      frame(1'b1, 1'b0, 1'b1, 1'b0);
    end
    frames(1'b1, 1'b0, 1'b1, 31);
    check("w_pre_x", int'(xpos_w), 1260);
    frame(1'b1, 1'b0, 1'b1, 1'b0);
    check("w_x", int'(xpos_w), 1276);
    check("w_v", int'(u_wrap.vel_q), 16);
    vpos = 12'sd700;
    for (int i = 0; i < 5; i++) begin
      hpos = 12'(hp_tab[i]);
      #1;
      check($sformatf("act_w_%0d", hp_tab[i]), int'(active_w), hp_exp[i]);
    end
    frame(1'b1, 1'b0, 1'b1, 1'b0);
    check("w_wrap_x", int'(xpos_w), 12);

    // Fire held from reset: shots after fsync 1, 10, 19
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("fire_p%0d", i), int'(got_pulse), (i == 1 || i == 10 || i == 19) ? 1 : 0);
      if (i == 1 || i == 10 || i == 19) check($sformatf("fire_x%0d", i), got_fx, 640);
    end

    // Left and right together decay velocity; debounce rejects a 2-cycle glitch
    do_reset();
    frames(1'b0, 1'b0, 1'b1, 3);
    check("lr_pre_v", int'(u_clamp.vel_q), 6);
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("lr_v%0d", i), int'(u_clamp.vel_q), lr_v[i]);
    end
    check("lr_x", int'(xpos_c), 626);
    right = 1'b1;
    repeat (2) @(negedge clk);
    right = 1'b0;
    repeat (6) @(negedge clk);
    sync_frame(1'b0);
    check("glitch_v", int'(u_clamp.vel_q), 0);
    right = 1'b1;
    repeat (3) @(negedge clk);
    right = 1'b0;
    repeat (6) @(negedge clk);
    sync_frame(1'b0);
    check("press3_v", int'(u_clamp.vel_q), 2);

    // Reset mid-cooldown at x=100 clears state with no clock edge
    do_reset();
    frames(1'b0, 1'b1, 1'b0, 8);
    check("l_ramp_x", int'(xpos_c), 552);
    for (int i = 0; i < 6; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b1, 1'b0, 1'b0);
    end
    frames(1'b0, 1'b1, 1'b0, 16);
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    check("cd_x", int'(xpos_c), 100);
    check("cd_pulse", int'(got_pulse), 1);
    check("cd_fire_x", got_fx, 132);
    check("cd_val", int'(u_clamp.cd_q), 8);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", int'(xpos_c), 608);
    check("arst_cd", int'(u_clamp.cd_q), 0);
    check("arst_v", int'(u_clamp.vel_q), 0);
    check("arst_fx", int'(fx_c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    check("arst_fire", int'(got_pulse), 1);
    check("arst_fire_x", got_fx, 640);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/player_ship.md
PLAYER_SHIP -- requirements
Module: player_ship

Interface
REQ-001 SHALL have parameter HRES, default 1280, horizontal resolution in pixels.
REQ-002 SHALL have parameter VRES, default 720, vertical resolution in pixels.
REQ-003 SHALL have parameter SHIP_W, default 64, sprite width in pixels (even, < HRES).
REQ-004 SHALL have parameter SHIP_H, default 32, sprite height in pixels.
REQ-005 SHALL have parameter MAX_VEL, default 16, maximum speed magnitude in pixels/frame.
REQ-006 SHALL have parameter ACCEL, default 2, velocity change per frame in pixels/frame.
REQ-007 SHALL have parameter DEB, default 3, debounce depth in cycles (>= 1).
REQ-008 SHALL have parameter EDGE_MODE, default 0, where 0 = clamp at screen edges and 1 = wrap around.
REQ-009 SHALL have parameter FIRE_CD, default 8, frames of fire cooldown.
REQ-010 SHALL have parameter COLOR, default 24'hEFE62E, RGB sprite colour.
REQ-011 SHALL have port pixel_clk  in  1  the single clock; all state on its rising edge.
REQ-012 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-013 SHALL have port fsync  in  1  one-cycle start-of-frame strobe.
REQ-014 SHALL have port hpos  in  signed 12  current pixel x.
REQ-015 SHALL have port vpos  in  signed 12  current pixel y.
REQ-016 SHALL have ports left, right, fire  in  1 each  raw button levels.
REQ-017 SHALL have port pixel  out  3x8  colour, BGR order: [2]=R, [1]=G, [0]=B.
REQ-018 SHALL have port active  out  1  current pixel inside the sprite.
REQ-019 SHALL have port xpos  out  signed 12  sprite left edge.
REQ-020 SHALL have port fire_pulse  out  1  one-cycle shot request.
REQ-021 SHALL have port fire_x  out  signed 12  shot x origin.

Function
REQ-022 SHALL treat each button as pressed only when its last DEB registered samples are all 1.
REQ-023 SHALL set each per-frame latch (L, R, F) on any non-fsync cycle where its button is pressed; latches SHALL clear on fsync.
REQ-024 SHALL treat the frame as no input when L and R are both latched.
REQ-025 SHALL, on fsync, update vel (signed) as follows:
- R only: min(vel+ACCEL, MAX_VEL).
- L only: max(vel-ACCEL, -MAX_VEL).
- None: decay toward 0 by ACCEL, never crossing 0.
REQ-026 SHALL, on the same fsync, compute nx = xpos + old vel.
REQ-027 SHALL, in clamp mode (EDGE_MODE=0), apply:
- nx < 0: xpos=0 and vel=0.
- nx > HRES-SHIP_W: xpos=HRES-SHIP_W and vel=0.
- Otherwise: xpos=nx.
REQ-028 SHALL, in wrap mode (EDGE_MODE=1), set xpos = nx+HRES if nx < 0, nx-HRES if nx >= HRES, else nx; vel is unaffected.
REQ-029 SHALL run a fire FSM with states READY (cd=0) and COOL (cd>0), where cd is the cooldown counter:
- On fsync in READY with F latched: fire_pulse=1 on the next cycle only; fire_x = new xpos + SHIP_W/2 (mod HRES in wrap mode); cd=FIRE_CD; go to COOL.
- On fsync in COOL: cd decrements; go to READY when cd reaches 0.
- F latched during COOL is discarded.
REQ-030 SHALL drive active combinationally:
- vpos within [VRES-SHIP_H, VRES-1], and
- 0 <= hpos < HRES, and
- (hpos-xpos) mod HRES < SHIP_W in wrap mode, or xpos <= hpos < xpos+SHIP_W in clamp mode.
REQ-031 SHALL output pixel = COLOR when active, else 0.
REQ-032 SHALL have no effect for non-fsync cycles on xpos, vel or cd.

Reset
REQ-033 SHALL, while rst_n=0, force:
- xpos=(HRES-SHIP_W)/2 and vel=0.
- Latches, debounce registers and cd to 0; FSM to READY.
- fire_pulse=0 and fire_x=0.
REQ-034 SHALL, when reset is asserted mid-frame or mid-cooldown, discard all pending latches and cooldown immediately, without waiting for a clock edge.
REQ-035 SHALL have the first fsync after reset release act on latches gathered since release only.

Verification
REQ-036 SHALL cover: defaults, right held across 3 fsyncs -> (xpos, vel) = (608,2), (610,4), (614,6).
REQ-037 SHALL cover: clamp mode, xpos=1210, vel=16 at fsync -> xpos=1216, vel=0; next right frame -> vel=2.
REQ-038 SHALL cover: wrap mode, xpos=1260, vel=16 at fsync -> xpos=1276; on sprite row, active=1 at hpos 1279 and 0..39, active=0 at hpos 40.
REQ-039 SHALL cover: fire held continuously from reset -> fire_pulse after fsync 1, 10, 19 (period 9); fire_x = xpos+32 each time.
REQ-040 SHALL cover: left and right held together with vel=6 -> vel 4, 2, 0, 0 over successive fsyncs; 2-cycle right glitch (DEB=3) -> no latch.
REQ-041 SHALL cover: rst_n low mid-cooldown with xpos=100 -> xpos=608, cd=0 with no clock edge; fire on the next frame pulses.
